// File: rtl/main1_datapath.sv
// main1_datapath: 32-bit single-bus Mini-SRC datapath (register file, special registers, ALU, CON, ports, RAM).
// Optional macro EXT_MEM_EN: MDR memory data comes from MDatain and the internal RAM is not built.
module main1_datapath #(
    parameter int MEM_DEPTH     = 512,
    parameter     MEM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        outPortin,
    input  logic        conIn,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        ZLowout,
    input  logic        ZHighout,
    input  logic        InPortout,
    input  logic        Cout,
    input  logic        conOut,
    input  logic        IncPC,
    input  logic        MDRread,
    input  logic        memWrite,
    input  logic [3:0]  ALUselect,
    input  logic [31:0] MDatain,
    input  logic [31:0] in_port,
    output logic [31:0] out_port,
    output logic [31:0] bus_out,
    output logic [31:0] pc_q,
    output logic [31:0] ir_q,
    output logic        con_q
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] r_q [16];
    logic [31:0] pc_reg_q, ir_reg_q, mar_q, mdr_q, hi_q, lo_q, y_q, inp_q, outp_q;
    logic [63:0] z_q, z_d;
    logic        con_reg_q, con_d;
    logic [31:0] bus, mdr_d, mem_rd;
    logic [3:0]  sel, alu_op;
    logic [4:0]  shamt;
    logic signed [63:0] prod;
    logic signed [31:0] quo, rem;

    assign sel = ({4{Gra}} & ir_reg_q[26:23]) | ({4{Grb}} & ir_reg_q[22:19]) |
                 ({4{Grc}} & ir_reg_q[18:15]);

    always_comb begin
        bus = '0;
        if (Rout)           bus = r_q[sel];
        else if (BAout)     bus = (sel == 4'd0) ? '0 : r_q[sel];
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (ZHighout)  bus = z_q[63:32];
        else if (ZLowout)   bus = z_q[31:0];
        else if (PCout)     bus = pc_reg_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inp_q;
        else if (Cout)      bus = {{13{ir_reg_q[18]}}, ir_reg_q[18:0]};
    end

    // ALU: A is Y, B is the bus; only mul and div produce a full 64-bit result
    always_comb begin
        alu_op = IncPC ? 4'b1001 : ALUselect;
        shamt  = bus[4:0];
        prod   = 64'($signed(y_q)) * 64'($signed(bus));
        quo    = '0;
        rem    = '0;
        if (bus != '0) begin
            quo = $signed(y_q) / $signed(bus);
            rem = $signed(y_q) % $signed(bus);
        end
        z_d = '0;
        case (alu_op)
            4'b0001: z_d = {32'd0, y_q + bus};
            4'b0010: z_d = {32'd0, y_q - bus};
            4'b0011: z_d = {32'd0, y_q >> shamt};
            4'b0100: z_d = {32'd0, $signed(y_q) >>> shamt};
            4'b0101: z_d = {32'd0, y_q << shamt};
            4'b0110: z_d = {32'd0, y_q & bus};
            4'b0111: z_d = {32'd0, y_q | bus};
            4'b1000: z_d = {32'd0, (y_q << shamt) | (y_q >> (6'd32 - {1'b0, shamt}))};
            4'b1001: z_d = {32'd0, bus + 32'd1};
            4'b1010: z_d = {32'd0, (y_q >> shamt) | (y_q << (6'd32 - {1'b0, shamt}))};
            4'b1011: z_d = {32'd0, -bus};
            4'b1100: z_d = {32'd0, ~bus};
            4'b1101: z_d = prod;
            4'b1110: z_d = {rem, quo};
            default: z_d = {32'd0, bus};
        endcase
    end

    always_comb begin
        case (ir_reg_q[20:19])
            2'b00:   con_d = (bus == '0);
            2'b01:   con_d = (bus != '0);
            2'b10:   con_d = ~bus[31];
            default: con_d = bus[31];
        endcase
    end

    assign mdr_d = MDRread ? mem_rd : bus;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            pc_reg_q  <= '0;
            ir_reg_q  <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            con_reg_q <= 1'b0;
            inp_q     <= '0;
            outp_q    <= '0;
        end else begin
            inp_q <= in_port;
            if (Rin)       r_q[sel]  <= bus;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (Yin)       y_q       <= bus;
            if (IRin)      ir_reg_q  <= bus;
            if (MARin)     mar_q     <= bus;
            if (outPortin) outp_q    <= bus;
            if (Zin)       z_q       <= z_d;
            if (MDRin)     mdr_q     <= mdr_d;
            if (conIn)     con_reg_q <= con_d;
            // conditional branch: with conOut the PC only moves when CON is set
            if (PCin && (!conOut || con_reg_q)) pc_reg_q <= bus;
        end
    end

`ifdef EXT_MEM_EN
    assign mem_rd = MDatain;
    logic unused_mem;
    assign unused_mem = ^{memWrite, mar_q};
`else
    logic [31:0] ram [MEM_DEPTH];

    // RAM captures the MDR value present before the edge, so a same-edge MDRin stores the old word
    always_ff @(posedge clk) begin
        if (memWrite) ram[mar_q[AW-1:0]] <= mdr_q;
    end

    assign mem_rd = ram[mar_q[AW-1:0]];
    logic unused_mem;
    assign unused_mem = ^{MDatain, mar_q[31:AW]};
`endif

    assign bus_out  = bus;
    assign pc_q     = pc_reg_q;
    assign ir_q     = ir_reg_q;
    assign con_q    = con_reg_q;
    assign out_port = outp_q;
endmodule

// File: tb/tb_main1_datapath.sv
// Self-checking bench for main1_datapath: reset, random register file / ALU traffic against a
// behavioural model, then the fetch / ldi / ld / st / addi / branch instruction sequences.
module tb_main1_datapath;
    logic clk = 1'b0, clr_n = 1'b0;
    logic Rin, Rout, BAout, Gra, Grb, Grc, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
    logic outPortin, conIn, HIout, LOout, PCout, MDRout, ZLowout, ZHighout, InPortout, Cout;
    logic conOut, IncPC, MDRread, memWrite;
    logic [3:0]  ALUselect;
    logic [31:0] MDatain = 32'h0, in_port = 32'h0;
    logic [31:0] out_port, bus_out, pc_q, ir_q;
    logic        con_q;

    int total = 0, bad = 0;
    logic [31:0] m_r [16];
    logic [31:0] obs, a, b, v, ir;
    logic [63:0] ez;
    int idx, g, op, c2;
    logic inc, ba, ec;

    main1_datapath dut (
        .clk(clk), .clr_n(clr_n), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .outPortin(outPortin), .conIn(conIn),
        .HIout(HIout), .LOout(LOout), .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout),
        .ZHighout(ZHighout), .InPortout(InPortout), .Cout(Cout), .conOut(conOut), .IncPC(IncPC),
        .MDRread(MDRread), .memWrite(memWrite), .ALUselect(ALUselect), .MDatain(MDatain),
        .in_port(in_port), .out_port(out_port), .bus_out(bus_out), .pc_q(pc_q), .ir_q(ir_q),
        .con_q(con_q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_ctl();
        {Rin, Rout, BAout, Gra, Grb, Grc, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin} = '0;
        {outPortin, conIn, HIout, LOout, PCout, MDRout, ZLowout, ZHighout, InPortout, Cout} = '0;
        {conOut, IncPC, MDRread, memWrite} = '0;
        ALUselect = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk); #1; clr_ctl();
    endtask

    // get a value onto the bus through the input port for the next cycle
    task automatic src(input logic [31:0] val);
        in_port = val; tick(); InPortout = 1'b1;
    endtask

    task automatic peek(output logic [31:0] val);
        #1; val = bus_out; clr_ctl();
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic gsel(input int gg);
        case (gg) 0: Gra = 1'b1; 1: Grb = 1'b1; default: Grc = 1'b1; endcase
    endtask

    task automatic write_ram(input logic [31:0] addr, input logic [31:0] data);
        src(addr); MARin = 1'b1; tick();
        src(data); MDRin = 1'b1; tick();
        memWrite = 1'b1; tick();
    endtask

    function automatic logic [31:0] mk_ir(input int gg, input int ri);
        logic [31:0] r;
        r = $urandom;
        case (gg)
            0:       r[26:23] = 4'(ri);
            1:       r[22:19] = 4'(ri);
            default: r[18:15] = 4'(ri);
        endcase
        return r;
    endfunction

    // reference ALU written from the operation table with wide arithmetic
    function automatic logic [63:0] alu_ref(input int o, input logic [31:0] x, input logic [31:0] y);
        int n;
        longint sx, sy;
        logic [63:0] xx;
        n  = int'(y[4:0]);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        xx = {x, x};
        case (o)
            1:  return {32'd0, x + y};
            2:  return {32'd0, x - y};
            3:  return {32'd0, x >> n};
            4:  return {32'd0, 32'(sx >>> n)};
            5:  return {32'd0, x << n};
            6:  return {32'd0, x & y};
            7:  return {32'd0, x | y};
            8:  return {32'd0, 32'((xx << n) >> 32)};
            9:  return {32'd0, y + 32'd1};
            10: return {32'd0, 32'(xx >> n)};
            11: return {32'd0, 32'd0 - y};
            12: return {32'd0, ~y};
            13: return 64'(sx * sy);
            14: return (y == 0) ? 64'd0 : {32'(sx % sy), 32'(sx / sy)};
            default: return {32'd0, y};
        endcase
    endfunction

    initial begin
        clr_ctl();
        repeat (2) @(posedge clk);
        #1; clr_n = 1'b1;
        chk("rst_pc", pc_q, 32'h0);
        chk("rst_ir", ir_q, 32'h0);
        chk("rst_bus_idle", bus_out, 32'h0);

        // load state, then reset mid-cycle and see it vanish immediately
        src(32'h0880_0000); IRin = 1'b1; tick();
        src(32'h55); Gra = 1'b1; Rin = 1'b1; tick();
        src(32'h1234);
        {HIin, LOin, Yin, PCin, outPortin, MDRin, MARin, Zin} = '1;
        tick();
        src(32'h0); conIn = 1'b1; tick();
        chk("pre_out", out_port, 32'h1234);
        chk("pre_con", {31'd0, con_q}, 32'd1);
        chk("pre_pc", pc_q, 32'h1234);
        @(posedge clk); #2; clr_n = 1'b0; #1;
        chk("arst_pc", pc_q, 32'h0);
        chk("arst_ir", ir_q, 32'h0);
        chk("arst_out", out_port, 32'h0);
        chk("arst_con", {31'd0, con_q}, 32'd0);
        HIout = 1'b1;   peek(obs); chk("arst_hi", obs, 32'h0);
        LOout = 1'b1;   peek(obs); chk("arst_lo", obs, 32'h0);
        ZLowout = 1'b1; peek(obs); chk("arst_z", obs, 32'h0);
        MDRout = 1'b1;  peek(obs); chk("arst_mdr", obs, 32'h0);
        clr_n = 1'b1;
        src(32'h0880_0000); IRin = 1'b1; tick();
        Gra = 1'b1; Rout = 1'b1; peek(obs); chk("arst_r1", obs, 32'h0);
        src(32'h0); ALUselect = 4'b0001; Zin = 1'b1; tick();
        ZLowout = 1'b1; peek(obs); chk("arst_y", obs, 32'h0);

        // random register file traffic through every select field
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        for (int k = 0; k < 24; k++) begin
            idx = $urandom_range(0, 15); g = $urandom_range(0, 2); v = $urandom;
            src(mk_ir(g, idx)); IRin = 1'b1; tick();
            src(v); gsel(g); Rin = 1'b1; tick();
            m_r[idx] = v;
            idx = $urandom_range(0, 15); g = $urandom_range(0, 2); ba = 1'($urandom_range(0, 1));
            src(mk_ir(g, idx)); IRin = 1'b1; tick();
            gsel(g);
            if (ba) BAout = 1'b1; else Rout = 1'b1;
            peek(obs);
            chk("regrd", obs, (ba && idx == 0) ? 32'h0 : m_r[idx]);
        end

        // random ALU operations, both halves of Z
        for (int k = 0; k < 48; k++) begin
            a = $urandom; b = $urandom;
            op  = $urandom_range(0, 15);
            inc = ($urandom_range(0, 7) == 0);
            if (op == 14 && $urandom_range(0, 3) == 0) b = 32'h0;
            src(a); Yin = 1'b1; tick();
            src(b); ALUselect = 4'(op); IncPC = inc; Zin = 1'b1; tick();
            ez = alu_ref(inc ? 9 : op, a, b);
            ZLowout = 1'b1;  peek(obs); chk("alu_zlo", obs, ez[31:0]);
            ZHighout = 1'b1; peek(obs); chk("alu_zhi", obs, ez[63:32]);
        end

        // bus priority
        src(32'hAAAA); HIin = 1'b1; tick();
        src(32'hBBBB); LOin = 1'b1; tick();
        HIout = 1'b1; LOout = 1'b1; peek(obs); chk("prio_hi_lo", obs, 32'hAAAA);
        src(32'h0); IRin = 1'b1; tick();
        src(32'hFFFF); Gra = 1'b1; Rin = 1'b1; tick();
        Gra = 1'b1; Rout = 1'b1; HIout = 1'b1; peek(obs); chk("prio_r_hi", obs, 32'hFFFF);

        // fetch from RAM[0]
        write_ram(32'h0, 32'h0880_0055);
        write_ram(32'h78, 32'hDEAD_BEEF);
        src(32'h0); PCin = 1'b1; tick();
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
        ZLowout = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; IRin = 1'b1; tick();
        chk("fetch_ir", ir_q, 32'h0880_0055);
        chk("fetch_pc", pc_q, 32'h1);

        // ldi R1,$85 (R0 holds 0xFFFF, BAout must still give 0)
        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; tick();
        Cout = 1'b1; ALUselect = 4'b0001; Zin = 1'b1; tick();
        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
        Gra = 1'b1; Rout = 1'b1; peek(obs); chk("ldi_r1", obs, 32'h55);

        // ld R0,$35(R1)
        src(32'h0008_0023); IRin = 1'b1; tick();
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
        Cout = 1'b1; ALUselect = 4'b0001; Zin = 1'b1; tick();
        ZLowout = 1'b1; peek(obs); chk("ld_addr", obs, 32'h78);
        ZLowout = 1'b1; MARin = 1'b1; tick();
        MDRread = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
        Gra = 1'b1; Rout = 1'b1; peek(obs); chk("ld_r0", obs, 32'hDEAD_BEEF);

        // st $90(R1),R1
        src(32'h1088_005A); IRin = 1'b1; tick();
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
        Cout = 1'b1; ALUselect = 4'b0001; Zin = 1'b1; tick();
        ZLowout = 1'b1; MARin = 1'b1; tick();
        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; tick();
        memWrite = 1'b1; tick();
        src(32'h0); MDRin = 1'b1; tick();
        MDRread = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; peek(obs); chk("st_ram_af", obs, 32'h55);

        // same-edge MDRin and memWrite store the old MDR
        src(32'h99); MDRin = 1'b1; tick();
        src(32'h77); MDRin = 1'b1; memWrite = 1'b1; tick();
        MDRout = 1'b1; peek(obs); chk("same_edge_mdr", obs, 32'h77);
        MDRread = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; peek(obs); chk("same_edge_ram", obs, 32'h99);

        // addi R2,R1,-5
        src(32'h590F_FFFB); IRin = 1'b1; tick();
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
        Cout = 1'b1; ALUselect = 4'b0001; Zin = 1'b1; tick();
        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
        Gra = 1'b1; Rout = 1'b1; peek(obs); chk("addi_r2", obs, 32'h50);

        // brnz R2,35 taken, then brzr not taken
        for (int t = 0; t < 2; t++) begin
            src(32'h5); PCin = 1'b1; tick();
            src(t == 0 ? 32'h9108_0023 : 32'h9100_0023); IRin = 1'b1; tick();
            Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; tick();
            chk(t == 0 ? "brnz_con" : "brzr_con", {31'd0, con_q}, t == 0 ? 32'd1 : 32'd0);
            PCout = 1'b1; Yin = 1'b1; tick();
            Cout = 1'b1; ALUselect = 4'b0001; Zin = 1'b1; tick();
            ZLowout = 1'b1; PCin = 1'b1; conOut = 1'b1; tick();
            chk(t == 0 ? "brnz_pc" : "brzr_pc", pc_q, t == 0 ? 32'h28 : 32'h5);
        end
        src(32'h33); PCin = 1'b1; tick();
        chk("pc_uncond", pc_q, 32'h33);

        // random CON conditions over all C2 codes
        for (int k = 0; k < 12; k++) begin
            c2 = $urandom_range(0, 3);
            v  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            ir = 32'h0; ir[20:19] = 2'(c2);
            src(ir); IRin = 1'b1; tick();
            src(v); conIn = 1'b1; tick();
            case (c2)
                0:       ec = (v == 0);
                1:       ec = (v != 0);
                2:       ec = ($signed(v) >= 0);
                default: ec = ($signed(v) < 0);
            endcase
            chk("con_cond", {31'd0, con_q}, {31'd0, ec});
        end

        src(32'hCAFE_F00D); outPortin = 1'b1; tick();
        chk("out_port", out_port, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
